// File: rtl/simple_source_load_pkg.sv
// Shared types and constants for the host-to-local source load path.
package simple_source_load_pkg;

   localparam int WORD_W            = 64;
   localparam int LANES             = 8;
   localparam int BEAT_W            = LANES * WORD_W;
   localparam int BYTES_PER_WORD    = 8;
   localparam int MAX_WORDS_NUM_DEF = 512;
   localparam int LANE_CNT_W        = 4;

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      STREAM,
      DRAIN
   } state_t;

   function automatic logic [31:0] min_words(input logic [31:0] a, input logic [31:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [63:0] words_to_bytes(input logic [31:0] n);
      return 64'(n) * 64'(BYTES_PER_WORD);
   endfunction

endpackage

// File: rtl/beat_unpacker.sv
// Splits one stream beat into up to LANES words, lowest lane first, one per cycle.
module beat_unpacker
   import simple_source_load_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [BEAT_W-1:0]     beat,
   input  logic [LANE_CNT_W-1:0] lanes,
   output logic [WORD_W-1:0]     word,
   output logic                  word_valid,
   output logic                  last_lane
);

   logic [BEAT_W-1:0]     shreg;
   logic [LANE_CNT_W-1:0] count;

   // A load may coincide with the last lane being emitted; that lane is already on word.
   always_ff @(posedge clk) begin
      if (reset) begin
         shreg <= '0;
         count <= '0;
      end else if (load) begin
         shreg <= beat;
         count <= lanes;
      end else if (count != '0) begin
         shreg <= shreg >> WORD_W;
         count <= count - LANE_CNT_W'(1);
      end
   end

   assign word       = shreg[WORD_W-1:0];
   assign word_valid = (count != '0);
   assign last_lane  = (count == LANE_CNT_W'(1));

endmodule

// File: rtl/simple_source_load.sv
// Pulls a block of 64-bit words from host memory into local word memory, chunk by chunk.
// Optional SIMPLE_SOURCE_LOAD_CHECKSUM_EN adds an XOR checksum of all written words.
//
// state  | meaning
// IDLE   | waiting for kick
// CMD    | one-cycle read command to the host read master
// STREAM | accepting beats and writing unpacked words
// DRAIN  | chunk written, waiting for read-master completion
module simple_source_load
   import simple_source_load_pkg::*;
#(
   parameter int MAX_WORDS_NUM = MAX_WORDS_NUM_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              kick,
   output logic              busy,
   input  logic [31:0]       offset,
   input  logic [31:0]       words,
   input  logic [63:0]       memory_addr,
   output logic [31:0]       addr,
   output logic [WORD_W-1:0] d,
   output logic              we,
   output logic              ctrl_start,
   input  logic              ctrl_done,
   output logic [63:0]       ctrl_addr_offset,
   output logic [63:0]       ctrl_xfer_size_in_bytes,
`ifdef SIMPLE_SOURCE_LOAD_CHECKSUM_EN
   output logic [WORD_W-1:0] checksum,
`endif
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic [BEAT_W-1:0] s_axis_tdata
);

   localparam logic [31:0] MAX_W = 32'(MAX_WORDS_NUM);

   state_t      state;
   logic [31:0] offset_q;
   logic [63:0] mem_q;
   logic [31:0] remaining;
   logic [31:0] consumed;
   logic [31:0] chunk;
   logic [31:0] beats_left;
   logic [31:0] words_left;
   logic        done_seen;

   logic        kick_accept;
   logic        beat_fire;
   logic        word_valid;
   logic        last_lane;
   logic [LANE_CNT_W-1:0] load_lanes;
   logic [31:0] consumed_n;
   logic [31:0] remaining_n;
   logic [31:0] chunk_n;
   logic [31:0] first_chunk;

   assign kick_accept = (state == IDLE) && kick && (words != 32'd0);
   assign first_chunk = min_words(words, MAX_W);
   assign consumed_n  = consumed + chunk;
   assign remaining_n = remaining - chunk;
   assign chunk_n     = min_words(remaining_n, MAX_W);

   // Ready while the unpacker is empty or on its last lane, so back-to-back beats give one word per cycle.
   assign s_axis_tready = (state == STREAM) && (beats_left != 32'd0) && (!word_valid || last_lane);
   assign beat_fire     = s_axis_tvalid && s_axis_tready;

   // Only the final beat of a chunk may carry fewer than LANES words.
   assign load_lanes = ((beats_left == 32'd1) && (chunk[2:0] != 3'd0)) ?
                       {1'b0, chunk[2:0]} : LANE_CNT_W'(LANES);

   beat_unpacker u_unpacker (
      .clk        (clk),
      .reset      (reset),
      .load       (beat_fire),
      .beat       (s_axis_tdata),
      .lanes      (load_lanes),
      .word       (d),
      .word_valid (word_valid),
      .last_lane  (last_lane)
   );

   assign we = word_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         state                   <= IDLE;
         busy                    <= 1'b1;
         ctrl_start              <= 1'b0;
         ctrl_addr_offset        <= '0;
         ctrl_xfer_size_in_bytes <= '0;
         addr                    <= '0;
         offset_q                <= '0;
         mem_q                   <= '0;
         remaining               <= '0;
         consumed                <= '0;
         chunk                   <= '0;
         beats_left              <= '0;
         words_left              <= '0;
         done_seen               <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               busy <= 1'b0;
               if (kick_accept) begin
                  offset_q                <= offset;
                  mem_q                   <= memory_addr;
                  remaining               <= words;
                  consumed                <= '0;
                  chunk                   <= first_chunk;
                  busy                    <= 1'b1;
                  ctrl_start              <= 1'b1;
                  ctrl_addr_offset        <= memory_addr;
                  ctrl_xfer_size_in_bytes <= words_to_bytes(first_chunk);
                  addr                    <= offset;
                  state                   <= CMD;
               end
            end
            CMD: begin
               ctrl_start <= 1'b0;
               beats_left <= (chunk + 32'd7) >> 3;
               words_left <= chunk;
               state      <= STREAM;
            end
            STREAM: begin
               if (ctrl_done)
                  done_seen <= 1'b1;
               if (beat_fire)
                  beats_left <= beats_left - 32'd1;
               if (word_valid) begin
                  words_left <= words_left - 32'd1;
                  addr       <= addr + 32'd1;
                  if (words_left == 32'd1)
                     state <= DRAIN;
               end
            end
            DRAIN: begin
               if (done_seen) begin
                  done_seen <= 1'b0;
                  consumed  <= consumed_n;
                  remaining <= remaining_n;
                  if (remaining_n == 32'd0) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     chunk                   <= chunk_n;
                     ctrl_start              <= 1'b1;
                     ctrl_addr_offset        <= mem_q + words_to_bytes(consumed_n);
                     ctrl_xfer_size_in_bytes <= words_to_bytes(chunk_n);
                     addr                    <= offset_q + consumed_n;
                     state                   <= CMD;
                  end
               end else if (ctrl_done) begin
                  done_seen <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SIMPLE_SOURCE_LOAD_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (reset || kick_accept)
         checksum <= '0;
      else if (word_valid)
         checksum <= checksum ^ d;
   end
`endif

endmodule

// File: tb/tb_simple_source_load.sv
// Directed bench for simple_source_load: vector table plus reset-mid-stream sequence.
module tb_simple_source_load;

   logic          clk = 1'b0;
   logic          reset;
   logic          kick;
   logic          busy;
   logic [31:0]   offset;
   logic [31:0]   words;
   logic [63:0]   memory_addr;
   logic [31:0]   addr;
   logic [63:0]   d;
   logic          we;
   logic          ctrl_start;
   logic          ctrl_done;
   logic [63:0]   ctrl_addr_offset;
   logic [63:0]   ctrl_xfer_size_in_bytes;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic [511:0]  s_axis_tdata;
`ifdef SIMPLE_SOURCE_LOAD_CHECKSUM_EN
   logic [63:0]   checksum;
`endif

   simple_source_load dut (
      .clk                     (clk),
      .reset                   (reset),
      .kick                    (kick),
      .busy                    (busy),
      .offset                  (offset),
      .words                   (words),
      .memory_addr             (memory_addr),
      .addr                    (addr),
      .d                       (d),
      .we                      (we),
      .ctrl_start              (ctrl_start),
      .ctrl_done               (ctrl_done),
      .ctrl_addr_offset        (ctrl_addr_offset),
      .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
`ifdef SIMPLE_SOURCE_LOAD_CHECKSUM_EN
      .checksum                (checksum),
`endif
      .s_axis_tvalid           (s_axis_tvalid),
      .s_axis_tready           (s_axis_tready),
      .s_axis_tdata            (s_axis_tdata)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [63:0] cmd_addr_q[$], cmd_size_q[$], pend_addr_q[$], pend_size_q[$];
   logic [31:0] wr_addr_q[$];
   logic [63:0] wr_data_q[$];
   int          wr_cyc_q[$];

   int gap_mode = 0, done_delay = 0, extra_cycles = 0;
   int beats_acc = 0, extra_acc = 0;

   typedef struct {
      logic [31:0] offset;
      logic [31:0] words;
      logic [63:0] mem;
      int          gap;
      int          done_delay;
      int          extra;
      int          second_kick;
      int          exp_cmds;
      logic [63:0] exp_last_addr;
      logic [63:0] exp_last_size;
      int          exp_beats;
      int          exp_lat;
      int          exp_span;
   } vec_t;

   function automatic logic [63:0] host_word(input logic [63:0] byte_addr);
      return {byte_addr[31:0] ^ 32'hC0DE_F00D, byte_addr[31:0] + 32'h1234_5678};
   endfunction

   function automatic logic [511:0] make_beat(input logic [63:0] base, input int i);
      logic [511:0] b;
      for (int j = 0; j < 8; j++)
         b[j*64 +: 64] = host_word(base + 64'((i * 8 + j) * 8));
      return b;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset === 1'b0 && we === 1'b1) begin
         wr_addr_q.push_back(addr);
         wr_data_q.push_back(d);
         wr_cyc_q.push_back(cyc);
      end
      if (reset === 1'b0 && ctrl_start === 1'b1) begin
         cmd_addr_q.push_back(ctrl_addr_offset);
         cmd_size_q.push_back(ctrl_xfer_size_in_bytes);
         pend_addr_q.push_back(ctrl_addr_offset);
         pend_size_q.push_back(ctrl_xfer_size_in_bytes);
      end
   end

   task automatic serve(input logic [63:0] base, input logic [63:0] size);
      int nb, i, n;
      bit hs, phase, aborted;
      nb = int'((size + 64'd63) / 64'd64);
      i = 0; n = 0; phase = 1'b0; aborted = 1'b0;
      while (i < nb && n < 4000) begin
         if (reset) begin
            aborted = 1'b1;
            break;
         end
         s_axis_tvalid = (gap_mode == 0) || phase;
         s_axis_tdata  = make_beat(base, i);
         #1;
         hs = s_axis_tvalid && s_axis_tready;
         @(negedge clk);
         if (hs) begin
            i++;
            beats_acc++;
         end
         phase = !phase;
         n++;
      end
      for (int k = 0; k < extra_cycles && !aborted; k++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = make_beat(base, i);
         #1;
         hs = s_axis_tvalid && s_axis_tready;
         @(negedge clk);
         if (hs) extra_acc++;
      end
      s_axis_tvalid = 1'b0;
      if (!aborted && !reset) begin
         repeat (done_delay) @(negedge clk);
         ctrl_done = 1'b1;
         @(negedge clk);
         ctrl_done = 1'b0;
      end
   endtask

   initial begin : host
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      ctrl_done     = 1'b0;
      forever begin
         @(negedge clk);
         if (pend_addr_q.size() > 0 && !reset)
            serve(pend_addr_q.pop_front(), pend_size_q.pop_front());
      end
   end

   task automatic clear_logs();
      cmd_addr_q.delete(); cmd_size_q.delete();
      pend_addr_q.delete(); pend_size_q.delete();
      wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
      beats_acc = 0; extra_acc = 0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int n, fall_cyc, nbad, ncmd_exp;
      logic [63:0] cks;
      clear_logs();
      gap_mode = v.gap; done_delay = v.done_delay; extra_cycles = v.extra;
      @(negedge clk);
      offset = v.offset; words = v.words; memory_addr = v.mem; kick = 1'b1;
      @(negedge clk);
      kick = 1'b0;
      check($sformatf("v%0d busy_after_kick", idx), 64'(busy), 64'(v.words != 0));
      if (v.second_kick > 0) begin
         repeat (v.second_kick) @(negedge clk);
         offset = 32'h0; words = 32'd100; memory_addr = 64'h0; kick = 1'b1;
         @(negedge clk);
         kick = 1'b0;
      end
      n = 0;
      while (busy && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (busy) check($sformatf("v%0d busy_timeout", idx), 64'(busy), 64'd0);
      fall_cyc = cyc;
      repeat (4) @(negedge clk);
      check($sformatf("v%0d busy_idle", idx), 64'(busy), 64'd0);
      check($sformatf("v%0d cmd_count", idx), 64'(cmd_addr_q.size()), 64'(v.exp_cmds));
      ncmd_exp = int'((v.words + 32'd511) / 32'd512);
      for (int c = 0; c < cmd_addr_q.size() && c < ncmd_exp; c++) begin
         check($sformatf("v%0d cmd%0d_addr", idx, c), cmd_addr_q[c], v.mem + 64'(c) * 64'd4096);
         check($sformatf("v%0d cmd%0d_size", idx, c), cmd_size_q[c],
               64'(((v.words - 32'(c * 512)) > 32'd512) ? 32'd512 : (v.words - 32'(c * 512))) * 64'd8);
      end
      if (v.exp_cmds > 0 && cmd_addr_q.size() > 0) begin
         check($sformatf("v%0d last_cmd_addr", idx), cmd_addr_q[cmd_addr_q.size()-1], v.exp_last_addr);
         check($sformatf("v%0d last_cmd_size", idx), cmd_size_q[cmd_size_q.size()-1], v.exp_last_size);
      end
      check($sformatf("v%0d write_count", idx), 64'(wr_addr_q.size()), 64'(v.words));
      nbad = 0;
      cks = '0;
      for (int k = 0; k < int'(v.words); k++) begin
         cks ^= host_word(v.mem + 64'(k) * 64'd8);
         if (k < wr_addr_q.size()) begin
            if (wr_addr_q[k] !== v.offset + 32'(k) || wr_data_q[k] !== host_word(v.mem + 64'(k) * 64'd8)) begin
               if (nbad == 0)
                  $display("v%0d first bad write %0d: addr=%0h data=%0h", idx, k, wr_addr_q[k], wr_data_q[k]);
               nbad++;
            end
         end
      end
      check($sformatf("v%0d bad_writes", idx), 64'(nbad), 64'd0);
      check($sformatf("v%0d beats_accepted", idx), 64'(beats_acc + extra_acc), 64'(v.exp_beats));
      if (v.exp_lat >= 0 && wr_cyc_q.size() > 0)
         check($sformatf("v%0d done_to_idle", idx), 64'(fall_cyc - wr_cyc_q[wr_cyc_q.size()-1]), 64'(v.exp_lat));
      if (v.exp_span >= 0 && wr_cyc_q.size() > 0)
         check($sformatf("v%0d write_span", idx), 64'(wr_cyc_q[wr_cyc_q.size()-1] - wr_cyc_q[0]), 64'(v.exp_span));
`ifdef SIMPLE_SOURCE_LOAD_CHECKSUM_EN
      check($sformatf("v%0d checksum", idx), checksum, cks);
`endif
   endtask

   vec_t vecs[7];
   vec_t rv;

   initial begin : main
      int n;
      //          offset        words    mem            gap dly ext 2nd cmds last_addr      last_size beats lat span
      vecs[0] = '{32'h100, 32'd16,   64'h1000,   0, 0,  0,  0,  1, 64'h1000,  64'd128,  2,   2,  15};
      vecs[1] = '{32'h200, 32'd1030, 64'h1000,   0, 0,  0,  0,  3, 64'h3000,  64'd48,   129, 2,  -1};
      vecs[2] = '{32'h40,  32'd3,    64'h8000,   0, 0,  10, 0,  1, 64'h8000,  64'd24,   1,   -1, 2};
      vecs[3] = '{32'h300, 32'd48,   64'h20000,  1, 0,  0,  0,  1, 64'h20000, 64'd384,  6,   2,  -1};
      vecs[4] = '{32'h500, 32'd20,   64'h4000,   0, 40, 0,  0,  1, 64'h4000,  64'd160,  3,   -1, -1};
      vecs[5] = '{32'h900, 32'd0,    64'h5000,   0, 0,  0,  0,  0, 64'h0,     64'd0,    0,   -1, -1};
      vecs[6] = '{32'h600, 32'd16,   64'h9000,   0, 0,  0,  5,  1, 64'h9000,  64'd128,  2,   2,  15};

      reset = 1'b1; kick = 1'b0; offset = '0; words = '0; memory_addr = '0;
      repeat (3) @(negedge clk);
      check("rst busy", 64'(busy), 64'd1);
      check("rst we", 64'(we), 64'd0);
      check("rst ctrl_start", 64'(ctrl_start), 64'd0);
      check("rst tready", 64'(s_axis_tready), 64'd0);
      check("rst addr", 64'(addr), 64'd0);
      check("rst d", d, 64'd0);
      check("rst ctrl_addr_offset", ctrl_addr_offset, 64'd0);
      check("rst xfer_size", ctrl_xfer_size_in_bytes, 64'd0);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst busy", 64'(busy), 64'd0);

      for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

      // Reset in the middle of a stream, then a clean 8-word load.
      clear_logs();
      gap_mode = 0; done_delay = 0; extra_cycles = 0;
      @(negedge clk);
      offset = 32'h700; words = 32'd64; memory_addr = 64'hA000; kick = 1'b1;
      @(negedge clk);
      kick = 1'b0;
      n = 0;
      while (wr_addr_q.size() < 10 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("midrst stream_started", 64'(wr_addr_q.size() >= 10), 64'd1);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("midrst busy", 64'(busy), 64'd1);
      check("midrst we", 64'(we), 64'd0);
      check("midrst tready", 64'(s_axis_tready), 64'd0);
      check("midrst addr", 64'(addr), 64'd0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst busy_released", 64'(busy), 64'd0);
      rv = '{32'hB00, 32'd8, 64'hC000, 0, 0, 0, 0, 1, 64'hC000, 64'd64, 1, 2, 7};
      run_vec(7, rv);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
